// File: rtl/vending_ctrl.sv
// Vending machine controller: coin credit, per-product stock, level-sampled purchase,
// and coin-by-coin change return. All state moves on the rising edge of clk.
module vending_ctrl #(
    parameter int                    NPROD       = 4,
    parameter int                    CW          = 6,
    parameter logic [NPROD*CW-1:0]   PRICES      = {CW'(7), CW'(5), CW'(3), CW'(2)},
    parameter int                    COIN_V1     = 2,
    parameter int                    COIN_V2     = 3,
    parameter int                    COIN_V3     = 4,
    parameter int                    SW          = 4,
    parameter int                    STOCK_INIT  = 2,
    parameter int                    AUTO_CHANGE = 1,
    localparam int                   SELW        = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        moneda,
    input  logic [NPROD-1:0]  buy,
    input  logic              cancel,
    input  logic              restock_en,
    input  logic [SELW-1:0]   restock_sel,
    output logic [NPROD-1:0]  listo,
    output logic [NPROD-1:0]  vend,
    output logic [CW-1:0]     total,
    output logic              chg_valid,
    output logic [1:0]        chg_val,
    output logic              coin_reject,
    output logic              sold_out,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [CW:0]   CREDIT_MAX = {1'b0, {CW{1'b1}}};
    localparam logic [SW-1:0] STOCK_MAX  = {SW{1'b1}};
    localparam logic [SW-1:0] STOCK_RST  = SW'(STOCK_INIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [SW-1:0]   stock_q [NPROD];
    logic [SW-1:0]   stock_d [NPROD];
    logic [SELW-1:0] sel_q, sel_d;
    logic            coin_reject_q, coin_reject_d;
    logic            sold_out_q, sold_out_d;

    logic [CW-1:0]   coin_val;
    logic [CW:0]     coin_sum;
    logic [NPROD-1:0] empty;
    logic            win_found;
    logic [SELW-1:0] win_idx;
    logic            buy_acc;
    logic            cancel_acc;
    logic [CW-1:0]   sel_price;
    logic [CW-1:0]   chg_amt;

    always_comb begin
        coin_val = '0;
        case (moneda)
            2'b01:   coin_val = CW'(COIN_V1);
            2'b10:   coin_val = CW'(COIN_V2);
            2'b11:   coin_val = CW'(COIN_V3);
            default: coin_val = '0;
        endcase
        coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

        empty = '0;
        listo = '0;
        for (int i = 0; i < NPROD; i++) begin
            empty[i] = (stock_q[i] == '0);
            listo[i] = (state_q == S_IDLE || state_q == S_CREDIT) &&
                       (credit_q >= PRICES[i*CW +: CW]) && !empty[i];
        end

        // Scan from the top so the lowest requested, ready product is the one left standing.
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NPROD - 1; i >= 0; i--) begin
            if (buy[i] && listo[i]) begin
                win_found = 1'b1;
                win_idx   = SELW'(i);
            end
        end

        sel_price  = PRICES[int'(sel_q)*CW +: CW];
        chg_amt    = (credit_q >= CW'(2)) ? CW'(2) : CW'(1);
        buy_acc    = (state_q == S_CREDIT) && !cancel && win_found;
        cancel_acc = (state_q == S_CREDIT) && cancel;
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        stock_d       = stock_q;
        sel_d         = sel_q;
        coin_reject_d = 1'b0;
        sold_out_d    = (state_q == S_CREDIT) && !cancel && !win_found && |(buy & empty);

        case (state_q)
            S_IDLE: begin
                if (credit_q != '0) state_d = S_CREDIT;
            end
            S_CREDIT: begin
                if (cancel_acc) begin
                    state_d = S_CHANGE;
                end else if (buy_acc) begin
                    state_d = S_VEND;
                    sel_d   = win_idx;
                end
            end
            S_VEND: begin
                credit_d = (credit_q >= sel_price) ? credit_q - sel_price : '0;
                if (stock_q[sel_q] != '0) stock_d[sel_q] = stock_q[sel_q] - SW'(1);
                if (credit_d == '0)         state_d = S_IDLE;
                else if (AUTO_CHANGE != 0)  state_d = S_CHANGE;
                else                        state_d = S_CREDIT;
            end
            S_CHANGE: begin
                credit_d = (credit_q > chg_amt) ? credit_q - chg_amt : '0;
                if (credit_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A coin is only banked when nothing else consumes this cycle and it fits.
        if (moneda != 2'b00) begin
            if ((state_q == S_IDLE || state_q == S_CREDIT) && !buy_acc && !cancel_acc &&
                coin_sum <= CREDIT_MAX)
                credit_d = coin_sum[CW-1:0];
            else
                coin_reject_d = 1'b1;
        end

        if (restock_en && int'(restock_sel) < NPROD) stock_d[restock_sel] = STOCK_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            sel_q         <= '0;
            coin_reject_q <= 1'b0;
            sold_out_q    <= 1'b0;
            for (int i = 0; i < NPROD; i++) stock_q[i] <= STOCK_RST;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            coin_reject_q <= coin_reject_d;
            sold_out_q    <= sold_out_d;
            stock_q       <= stock_d;
        end
    end

    assign total       = credit_q;
    assign busy        = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign chg_valid   = (state_q == S_CHANGE);
    assign chg_val     = chg_valid ? chg_amt[1:0] : 2'b00;
    assign vend        = (state_q == S_VEND) ? (NPROD'(1) << sel_q) : '0;
    assign coin_reject = coin_reject_q;
    assign sold_out    = sold_out_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: directed scenarios plus random traffic, checked every cycle
// against a purchase/change plan model through an expected-output queue.
module tb_vending_ctrl;

  localparam int NPROD = 4;
  localparam int CW    = 6;
  localparam int W     = 20;
  localparam int PRICE [4] = '{2, 3, 5, 7};
  localparam int COINV [4] = '{0, 2, 3, 4};

  // Handshake: the driver pushes one expected output word for every non-reset cycle
  // right after the edge; the monitor pops and compares one word at each falling edge.

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       moneda = '0;
  logic [NPROD-1:0] buy = '0;
  logic             cancel = 1'b0;
  logic             restock_en = 1'b0;
  logic [1:0]       restock_sel = '0;
  logic [NPROD-1:0] listo, vend;
  logic [CW-1:0]    total;
  logic             chg_valid, coin_reject, sold_out, busy;
  logic [1:0]       chg_val, dbg_state;

  vending_ctrl dut (
    .clk(clk), .reset(reset), .moneda(moneda), .buy(buy), .cancel(cancel),
    .restock_en(restock_en), .restock_sel(restock_sel), .listo(listo), .vend(vend),
    .total(total), .chg_valid(chg_valid), .chg_val(chg_val), .coin_reject(coin_reject),
    .sold_out(sold_out), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Reference model: credit, stock, and a plan of upcoming service cycles
  // (100+p = dispense product p, 1/2 = hand back a coin of that value).
  int m_credit;
  int m_stock [4];
  int plan[$];
  bit m_ready, m_rej, m_sold;

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < NPROD; i++) m_stock[i] = 2;
    plan.delete();
    m_ready = 0; m_rej = 0; m_sold = 0;
  endtask

  task automatic queue_change();
    int c;
    c = m_credit;
    while (c >= 2) begin plan.push_back(2); c -= 2; end
    if (c == 1) plan.push_back(1);
  endtask

  task automatic model_step();
    logic [3:0] e_listo, e_vend;
    logic [1:0] e_val;
    bit e_busy, e_cv, buy_ok, cancel_ok;
    int item, old_credit, v;
    e_busy = plan.size() > 0;
    e_listo = '0; e_vend = '0; e_cv = 0; e_val = '0;
    for (int i = 0; i < NPROD; i++)
      e_listo[i] = !e_busy && m_credit >= PRICE[i] && m_stock[i] > 0;
    if (e_busy) begin
      item = plan[0];
      if (item >= 100) e_vend[item-100] = 1'b1;
      else begin e_cv = 1; e_val = item[1:0]; end
    end
    exp_q.push_back({e_listo, e_vend, e_cv, e_val, 6'(m_credit), m_rej, m_sold, e_busy});

    m_rej = 0; m_sold = 0;
    if (e_busy) begin
      m_ready = 0;
      item = plan.pop_front();
      if (item >= 100) begin
        m_credit -= PRICE[item-100];
        m_stock[item-100]--;
        if (m_credit > 0) queue_change();
      end else begin
        m_credit -= item;
      end
      if (moneda != 0) m_rej = 1;
    end else begin
      buy_ok = 0;
      cancel_ok = m_ready && cancel;
      old_credit = m_credit;
      if (m_ready && !cancel) begin
        for (int i = 0; i < NPROD; i++)
          if (!buy_ok && buy[i] && e_listo[i]) begin
            buy_ok = 1;
            plan.push_back(100 + i);
          end
        if (!buy_ok)
          for (int i = 0; i < NPROD; i++)
            if (buy[i] && m_stock[i] == 0) m_sold = 1;
      end
      if (cancel_ok) queue_change();
      if (moneda != 0) begin
        v = COINV[moneda];
        if (!buy_ok && !cancel_ok && m_credit + v <= 63) m_credit += v;
        else m_rej = 1;
      end
      m_ready = !buy_ok && !cancel_ok && old_credit != 0;
    end
    if (restock_en && restock_sel < NPROD) m_stock[restock_sel] = 15;
  endtask

  task automatic step(input logic [1:0] m, input logic [3:0] b, input logic c,
                      input logic re, input logic [1:0] rs);
    @(posedge clk);
    #1;
    moneda = m; buy = b; cancel = c; restock_en = re; restock_sel = rs;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 4'b0000, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    moneda = '0; buy = '0; cancel = 1'b0; restock_en = 1'b0; restock_sel = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    model_step();
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor
  initial begin
    logic [W-1:0] e, got;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {listo, vend, chg_valid, chg_val, total, coin_reject, sold_out, busy};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL cycle_%0d outputs {listo,vend,cv,cval,total,rej,sold,busy}: got %h expected %h",
                   cyc_n, got, e);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();
    idle(2);

    // Two small coins, unaffordable buy, then a buy with one coin of change.
    step(2'b01, 4'b0000, 0, 0, 0);
    step(2'b01, 4'b0000, 0, 0, 0);
    idle(1);
    step(2'b00, 4'b0100, 0, 0, 0);
    step(2'b00, 4'b0010, 0, 0, 0);
    idle(4);
    chk("total_after_first_purchase", int'(total), 0);

    // Credit 7 then cancel: 2,2,2,1.
    step(2'b11, 4'b0000, 0, 0, 0);
    step(2'b10, 4'b0000, 0, 0, 0);
    idle(1);
    step(2'b00, 4'b0000, 1, 0, 0);
    idle(6);

    // Credit 62, then an overflowing coin.
    for (int i = 0; i < 15; i++) step(2'b11, 4'b0000, 0, 0, 0);
    step(2'b01, 4'b0000, 0, 0, 0);
    idle(1);
    step(2'b11, 4'b0000, 0, 0, 0);
    step(2'b00, 4'b0000, 0, 0, 0);
    chk("total_after_overflow_coin", int'(total), 62);
    step(2'b00, 4'b0000, 1, 0, 0);
    idle(34);

    // Sell product 0 out, then restock it.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 4'b0000, 0, 0, 0);
      idle(2);
      step(2'b00, 4'b0001, 0, 0, 0);
      idle(3);
    end
    step(2'b00, 4'b0000, 0, 1, 2'd0);
    step(2'b00, 4'b0001, 0, 0, 0);
    idle(4);

    // Credit 8, two simultaneous requests.
    do_reset();
    step(2'b11, 4'b0000, 0, 0, 0);
    step(2'b11, 4'b0000, 0, 0, 0);
    idle(1);
    step(2'b00, 4'b1010, 0, 0, 0);
    idle(6);

    // Reset in the middle of change return, then confirm stock went back to 2.
    step(2'b11, 4'b0000, 0, 0, 0);
    step(2'b10, 4'b0000, 0, 0, 0);
    idle(1);
    step(2'b00, 4'b0000, 1, 0, 0);
    idle(2);
    do_reset();
    idle(1);
    for (int k = 0; k < 3; k++) begin
      step(2'b11, 4'b0000, 0, 0, 0);
      idle(2);
      step(2'b00, 4'b0001, 0, 0, 0);
      idle(3);
    end

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
             ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
             $urandom_range(0, 24) == 0,
             $urandom_range(0, 39) == 0,
             2'($urandom_range(0, 3)));
      end
    end
    idle(40);

    @(negedge clk);
    @(negedge clk);
    chk("expected_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
